// File: rtl/fire_pkg.sv
// rtl/fire_pkg.sv - shared constants, state type and requantize helper for fire4 expand1 bias/ReLU
package fire_pkg;

  localparam int NUM_CH = 128;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 8;
  localparam int CH_W   = $clog2(NUM_CH);

  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // ReLU, arithmetic shift down to activation scale, then clamp to the positive signed range.
  function automatic logic [OUT_W-1:0] sat_relu(input logic signed [ACC_W:0] sum);
    logic signed [ACC_W:0] shifted;
    shifted = sum >>> SHIFT;
    if (sum[ACC_W]) return '0;
    if (shifted > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    return shifted[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/bias_relu_ctrl_fire4_expand1_if.sv
// rtl/bias_relu_ctrl_fire4_expand1_if.sv - accumulator input and activation output streams
interface bias_relu_ctrl_fire4_expand1_if;
  import fire_pkg::*;

  logic [ACC_W-1:0] acc_data;
  logic             acc_valid;
  logic             acc_ready;
  logic [OUT_W-1:0] out_data;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output acc_data, acc_valid, out_ready,
    input  acc_ready, out_data, out_ch, out_last, out_valid
  );

  modport slave (
    input  acc_data, acc_valid, out_ready,
    output acc_ready, out_data, out_ch, out_last, out_valid
  );

endinterface

// File: rtl/bias_relu_pipe.sv
// rtl/bias_relu_pipe.sv - two-stage bias add / ReLU / saturate datapath with global stall
module bias_relu_pipe
  import fire_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_valid,
  input  logic [ACC_W-1:0] beat_data,
  input  logic [ACC_W-1:0] beat_bias,
  input  logic [CH_W-1:0]  beat_ch,
  input  logic             beat_last,
  input  logic             out_ready,
  output logic             advance,
  output logic [OUT_W-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_last,
  output logic             out_valid
);

  logic                    s1_valid;
  logic signed [ACC_W:0]   s1_sum;
  logic [CH_W-1:0]         s1_ch;
  logic                    s1_last;

  // Whole pipe moves together; a held output freezes S1 as well.
  assign advance = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_ch     <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_valid  <= beat_valid;
      s1_sum    <= {beat_data[ACC_W-1], beat_data} + {beat_bias[ACC_W-1], beat_bias};
      s1_ch     <= beat_ch;
      s1_last   <= beat_last && beat_valid;
      out_valid <= s1_valid;
      out_data  <= sat_relu(s1_sum);
      out_ch    <= s1_ch;
      out_last  <= s1_last;
    end
  end

endmodule

// File: rtl/bias_relu_ctrl_fire4_expand1.sv
// rtl/bias_relu_ctrl_fire4_expand1.sv - layer FSM, channel/pixel tracking and bias selection
module bias_relu_ctrl_fire4_expand1
  import fire_pkg::*;
#(
  parameter int NUM_PIX = 3025
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_CH-1:0][ACC_W-1:0]  bias_mem,
  bias_relu_ctrl_fire4_expand1_if.slave stream,
  output logic                          busy,
  output logic                          done
);

  localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  state_t           state;
  state_t           state_next;
  logic [CH_W-1:0]  ch_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic             primed;
  logic             advance;
  logic             accept;
  logic             final_beat;
  logic             last_fire;

  assign final_beat = (ch_cnt == CH_W'(NUM_CH-1)) && (pix_cnt == PIX_W'(NUM_PIX-1));
  // primed keeps acc_ready low during the first RUN cycle after start.
  assign stream.acc_ready = (state == RUN) && primed && advance;
  assign accept    = stream.acc_valid && stream.acc_ready;
  assign last_fire = stream.out_valid && stream.out_ready && stream.out_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && final_beat) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_fire) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
      primed  <= 1'b0;
    end else begin
      primed <= (state == RUN);
      if (state == IDLE && start) begin
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end else if (accept) begin
        if (ch_cnt == CH_W'(NUM_CH-1)) begin
          ch_cnt  <= '0;
          pix_cnt <= pix_cnt + 1'b1;
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
    end
  end

  bias_relu_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .beat_valid (accept),
    .beat_data  (stream.acc_data),
    .beat_bias  (bias_mem[ch_cnt]),
    .beat_ch    (ch_cnt),
    .beat_last  (final_beat),
    .out_ready  (stream.out_ready),
    .advance    (advance),
    .out_data   (stream.out_data),
    .out_ch     (stream.out_ch),
    .out_last   (stream.out_last),
    .out_valid  (stream.out_valid)
  );

endmodule

// File: tb/tb_bias_relu_ctrl_fire4_expand1.sv
// tb/tb_bias_relu_ctrl_fire4_expand1.sv - randomized scoreboard bench, two-pixel layer
module tb_bias_relu_ctrl_fire4_expand1;
  import fire_pkg::*;

  localparam int NPIX  = 2;
  localparam int TOTAL = NUM_CH * NPIX;

  typedef struct {
    longint data;
    int     ch;
    bit     last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [NUM_CH-1:0][ACC_W-1:0] bias_mem;

  bias_relu_ctrl_fire4_expand1_if bus();

  bias_relu_ctrl_fire4_expand1 #(.NUM_PIX(NPIX)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias_mem (bias_mem),
    .stream   (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  beat_t  exp_q[$];
  int     idx = 0;
  int     out_cnt = 0;
  int     done_cnt = 0;
  int     cyc = 0;
  int     last_cyc = -1;
  int     done_cyc = -1;
  bit     acc_taken = 1'b0;
  longint got[16];

  task automatic check(string tag, longint obs, longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint ref_out(logic [31:0] acc, logic [31:0] bias);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(bias));
    if (s < 0) return 0;
    s = s / 256;
    return (s > 32767) ? 32767 : s;
  endfunction

  function automatic logic [31:0] rand_acc(int i);
    int v;
    if (i == 3) return 32'd25600;
    if (i == 8) return 32'h7FFF_0000;
    if (i < 8) return '0;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin
        v = int'($urandom_range(0, 1048575)) - 524288;
        return v;
      end
      2: return 32'h007F_0000 + $urandom_range(0, 65535);
      default: return 32'($urandom_range(0, 65535));
    endcase
  endfunction

  always @(negedge clk) begin : mon
    beat_t e;
    beat_t n;
    cyc++;
    acc_taken = 1'b0;
    if (rst) begin
      exp_q.delete();
      idx     = 0;
      out_cnt = 0;
    end else begin
      if (start && !busy && !done) begin
        idx     = 0;
        out_cnt = 0;
      end
      if (bus.acc_valid && bus.acc_ready) begin
        acc_taken = 1'b1;
        n.ch   = idx % NUM_CH;
        n.data = ref_out(bus.acc_data, bias_mem[n.ch]);
        n.last = (idx == TOTAL - 1);
        exp_q.push_back(n);
        idx++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_ch", bus.out_ch, e.ch);
          check("out_last", bus.out_last, e.last);
        end
        if (out_cnt < 16) got[out_cnt] = bus.out_data;
        if (bus.out_last) last_cyc = cyc;
        out_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic tick(int pv, int pr);
    if (acc_taken || !bus.acc_valid) begin
      bus.acc_valid = ($urandom_range(0, 99) < pv);
      bus.acc_data  = rand_acc(idx);
    end
    bus.out_ready = ($urandom_range(0, 99) < pr);
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idx(int target);
    int n = 0;
    while (idx < target && n < 4000) begin
      tick(70, 75);
      n++;
    end
    check("reach_idx", idx >= target, 1);
  endtask

  task automatic run_to_done(int d0);
    int n = 0;
    while (done_cnt == d0 && n < 4000) begin
      tick(70, 75);
      n++;
    end
    check("done_seen", done_cnt, d0 + 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(70, 75);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_run_ready", bus.acc_ready, 0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_ch"}, bus.out_ch, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_acc_ready"}, bus.acc_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    longint cap_data;
    longint cap_ch;
    int     n;
    int     d0;

    rst           = 1'b1;
    start         = 1'b0;
    bus.acc_valid = 1'b0;
    bus.acc_data  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      bias_mem[i] = 32'(int'($urandom_range(0, 4000)) - 2000);
    end
    bias_mem[0] = 32'hFFFF_FFA3;
    bias_mem[3] = 32'd100;
    bias_mem[8] = 32'd461;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // acc_valid while idle must be ignored
    bus.acc_valid = 1'b1;
    bus.acc_data  = '0;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("idle_acc_ready", bus.acc_ready, 0);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_busy", busy, 0);
    end
    check("idle_no_accept", idx, 0);

    // pass 1: random gaps, stall near the pixel wrap, stray start
    do_start();
    run_to_idx(125);
    tick(100, 0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick(100, 0);
      n++;
    end
    check("stall_fill", bus.out_valid, 1);
    cap_data = bus.out_data;
    cap_ch   = bus.out_ch;
    repeat (5) begin
      tick(100, 0);
      check("stall_acc_ready", bus.acc_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data", bus.out_data, cap_data);
      check("stall_out_ch", bus.out_ch, cap_ch);
    end
    run_to_idx(150);
    start = 1'b1;
    tick(70, 75);
    start = 1'b0;
    check("start_while_busy", busy, 1);
    run_to_done(0);
    check("pass1_outputs", out_cnt, TOTAL);
    check("pass1_queue_empty", exp_q.size(), 0);
    check("done_latency", done_cyc - last_cyc, 1);
    check("relu_ch0", got[0], 0);
    check("bias_ch3", got[3], 100);
    check("sat_ch8", got[8], 32767);
    repeat (5) tick(70, 75);
    check("done_once", done_cnt, 1);
    check("idle_after_pass1", busy, 0);

    // pass 2: reset at pixel 1 channel 40
    do_start();
    run_to_idx(NUM_CH + 40);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midrst");
    rst = 1'b0;
    d0 = done_cnt;
    repeat (8) tick(70, 75);
    check("no_done_after_rst", done_cnt, d0);
    check("idle_after_rst", busy, 0);

    // pass 3: clean restart from ch0/pix0
    do_start();
    run_to_done(d0);
    check("pass3_outputs", out_cnt, TOTAL);
    check("pass3_queue_empty", exp_q.size(), 0);
    check("pass3_done_latency", done_cyc - last_cyc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
